ltsm_sb_msg_arbiter: RTL and testbench
======================================

Name: ltsm_sb_msg_arbiter

Overview:
- Shares the single sideband message-transmit path between the TX-side and RX-side sub-FSMs of an LTSM training state (SBINIT, MBINIT, ...).
- Grants one requester at a time and latches its encoded message.
- Drives the message to the SB encoder and tracks the SB busy handshake.
- Returns a per-owner completion pulse, so neither sub-FSM has to watch the other's valid.

Parameters:
- SB_MSG_WIDTH, 4, width of the encoded sideband message code.
- TIMEOUT_CYCLES, 1023, cycles allowed in ISSUE for i_SB_Busy to rise before the grant is abandoned.
- CNT_WIDTH, 10, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock; the single clock for the block.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid_tx  in  1  TX sub-FSM requests a send.
- i_encoded_SB_msg_tx  in  SB_MSG_WIDTH  TX message code.
- i_valid_rx  in  1  RX sub-FSM requests a send.
- i_encoded_SB_msg_rx  in  SB_MSG_WIDTH  RX message code.
- i_SB_Busy  in  1  SB encoder is serialising the current message.
- o_encoded_SB_msg  out  SB_MSG_WIDTH  message presented to the SB encoder.
- o_msg_valid  out  1  message valid to the SB encoder.
- o_done_tx  out  1  one-cycle pulse: TX message fully sent.
- o_done_rx  out  1  one-cycle pulse: RX message fully sent.
- o_tx_active  out  1  TX currently owns the path; RX sub-FSM uses it as its "tx busy" input.
- o_falling_edge_busy  out  1  one-cycle pulse on the 1->0 transition of i_SB_Busy.
- o_timeout  out  1  one-cycle pulse: the grant was abandoned because busy never rose.

Behaviour:
- Reset (i_rst high at a clock edge):
  - State = IDLE.
  - All outputs = 0; o_encoded_SB_msg = 0.
  - busy_q = 0, timeout counter = 0.
  - last_owner = RX, so TX wins the first tie.
  - Reset mid-transfer aborts silently; no done pulse is issued.
- Busy edge detect:
  - busy_q <= i_SB_Busy every cycle.
  - o_falling_edge_busy = busy_q & ~i_SB_Busy (combinational from registered state).
- State IDLE:
  - If either valid is high, go to ISSUE next cycle.
  - Latch the winner's message into o_encoded_SB_msg and record owner.
  - Only one valid high: that requester wins.
  - Both high: the requester that is not last_owner wins (round-robin).
  - Latency: request in cycle N gives o_msg_valid = 1 in cycle N+1.
- State ISSUE:
  - o_msg_valid = 1; timeout counter increments each cycle.
  - i_SB_Busy = 1: go to BUSY and clear the counter.
  - Otherwise, if the owner's valid drops (withdrawn): return to IDLE, clear o_msg_valid, no done pulse, last_owner unchanged.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: pulse o_timeout, go to IDLE, clear o_msg_valid, set last_owner = owner.
  - Busy rise takes priority over both withdrawal and timeout in the same cycle.
- State BUSY:
  - o_msg_valid stays 1 and the message is held stable.
  - Owner valid changes are ignored.
  - On o_falling_edge_busy: go to DONE and clear o_msg_valid.
- State DONE (exactly one cycle):
  - Pulse o_done_tx or o_done_rx for the owner; set last_owner = owner.
  - Return to IDLE.
  - A new request is evaluated in the following IDLE cycle, so the minimum gap between consecutive grants is 1 idle cycle.
- o_tx_active:
  - 1 in ISSUE, BUSY and DONE when owner = TX; else 0.
  - Registered together with the state, with no combinational path from the inputs.
- Message hold rules:
  - o_encoded_SB_msg changes only on a grant in IDLE.
  - It holds its last value afterwards and is not cleared on done.
- Illegal state encodings go to IDLE on the next clock.

Test Plan:
- TX only: i_valid_tx = 1, msg = 4'h1; busy rises at cycle 3 and falls at cycle 8 -> o_msg_valid cycles 1-8, o_encoded_SB_msg = 4'h1, o_done_tx pulse at cycle 9, o_tx_active = 1 cycles 1-9.
- Simultaneous requests from reset: TX msg 4'h1, RX msg 4'h2, both held -> TX served first, then RX granted after TX's done plus 1 idle cycle, o_encoded_SB_msg = 4'h2, o_done_rx pulses; a third tie after that goes to TX.
- Withdrawal: RX requests, then drops i_valid_rx in ISSUE before busy rises -> return to IDLE, no o_done_rx, no o_timeout; drop during BUSY -> still completes with an o_done_rx pulse.
- Timeout: TIMEOUT_CYCLES = 8, TX requests, busy never rises -> o_timeout pulses on the 8th ISSUE cycle, o_msg_valid = 0 the next cycle, a waiting RX is granted next.
- Reset mid-BUSY: i_rst asserted during BUSY -> all outputs 0 on the next clock, no done pulse, a pending TX request is regranted after i_rst deasserts.
- Edge detect: i_SB_Busy toggles 1->0 while IDLE -> o_falling_edge_busy pulses for 1 cycle; no done pulse and no state change.

Source files
------------

// File: rtl/ltsm_sb_msg_arbiter_if.sv
// Bundle between the TX/RX training sub-FSMs, the SB encoder and the message arbiter.
// Latency: none, wires only.
// Backpressure: the SB encoder stalls the owner through i_SB_Busy. The losing requester keeps its valid high until it is served.
interface ltsm_sb_msg_arbiter_if #(
    parameter int SB_MSG_WIDTH = 4
);
    logic                    i_valid_tx;
    logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_tx;
    logic                    i_valid_rx;
    logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_rx;
    logic                    i_SB_Busy;
    logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg;
    logic                    o_msg_valid;
    logic                    o_done_tx;
    logic                    o_done_rx;
    logic                    o_tx_active;
    logic                    o_falling_edge_busy;
    logic                    o_timeout;

    // Requesters and encoder side: drives requests and busy, observes the arbiter.
    modport master (
        output i_valid_tx, i_encoded_SB_msg_tx, i_valid_rx, i_encoded_SB_msg_rx, i_SB_Busy,
        input  o_encoded_SB_msg, o_msg_valid, o_done_tx, o_done_rx, o_tx_active,
               o_falling_edge_busy, o_timeout
    );

    // Arbiter side.
    modport slave (
        input  i_valid_tx, i_encoded_SB_msg_tx, i_valid_rx, i_encoded_SB_msg_rx, i_SB_Busy,
        output o_encoded_SB_msg, o_msg_valid, o_done_tx, o_done_rx, o_tx_active,
               o_falling_edge_busy, o_timeout
    );
endinterface

// File: rtl/ltsm_sb_msg_arbiter.sv
// Shares one sideband transmit path between the TX and RX LTSM sub-FSMs. It uses round-robin on ties.
// Latency: request in cycle N gives o_msg_valid in N+1. A done pulse comes 1 cycle after busy falls.
// Backpressure: the owner is held while i_SB_Busy is high. A grant is abandoned if busy does not rise within TIMEOUT_CYCLES.
module ltsm_sb_msg_arbiter #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ltsm_sb_msg_arbiter_if.slave  sb_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic OWNER_TX = 1'b0;
    localparam logic OWNER_RX = 1'b1;

    // Counter value seen in the last ISSUE cycle allowed before the grant is dropped.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                  state;
    logic                    owner;
    logic                    last_owner;
    logic                    busy_q;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [SB_MSG_WIDTH-1:0] msg_q;
    logic                    msg_vld_q;
    logic                    done_tx_q;
    logic                    done_rx_q;
    logic                    tx_active_q;

    logic                    owner_vld;
    logic                    grant_rx;
    logic                    busy_fall;
    logic                    timeout_hit;

    // Owner's request line, and who wins in IDLE.
    // RX wins when it is alone, or when both request and TX was served last.
    always_comb begin
        owner_vld = (owner == OWNER_TX) ? sb_if.i_valid_tx : sb_if.i_valid_rx;
        grant_rx  = sb_if.i_valid_rx & (~sb_if.i_valid_tx | (last_owner == OWNER_TX));
    end

    // Falling edge of encoder busy, and the abandon condition.
    // A busy rise and a withdrawal both outrank the timeout.
    always_comb begin
        busy_fall   = busy_q & ~sb_if.i_SB_Busy;
        timeout_hit = (state == ST_ISSUE) & ~sb_if.i_SB_Busy & owner_vld & (cnt == CNT_LAST);
    end

    // One-cycle delayed copy of busy for the edge detector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= sb_if.i_SB_Busy;
        end
    end

    // Grant / issue / busy / done sequencing. Every output is registered with the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            owner       <= OWNER_TX;
            last_owner  <= OWNER_RX;
            cnt         <= '0;
            msg_q       <= '0;
            msg_vld_q   <= 1'b0;
            done_tx_q   <= 1'b0;
            done_rx_q   <= 1'b0;
            tx_active_q <= 1'b0;
        end else begin
            done_tx_q <= 1'b0;
            done_rx_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sb_if.i_valid_tx | sb_if.i_valid_rx) begin
                        state       <= ST_ISSUE;
                        owner       <= grant_rx ? OWNER_RX : OWNER_TX;
                        msg_q       <= grant_rx ? sb_if.i_encoded_SB_msg_rx
                                                : sb_if.i_encoded_SB_msg_tx;
                        msg_vld_q   <= 1'b1;
                        tx_active_q <= ~grant_rx;
                        cnt         <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (sb_if.i_SB_Busy) begin
                        state <= ST_BUSY;
                        cnt   <= '0;
                    end else if (!owner_vld) begin
                        // Withdrawn before the encoder accepted it: drop quietly.
                        state       <= ST_IDLE;
                        msg_vld_q   <= 1'b0;
                        tx_active_q <= 1'b0;
                        cnt         <= '0;
                    end else if (timeout_hit) begin
                        // The encoder never answered. Let the other side go next.
                        state       <= ST_IDLE;
                        msg_vld_q   <= 1'b0;
                        tx_active_q <= 1'b0;
                        last_owner  <= owner;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_BUSY: begin
                    if (busy_fall) begin
                        state     <= ST_DONE;
                        msg_vld_q <= 1'b0;
                        done_tx_q <= (owner == OWNER_TX);
                        done_rx_q <= (owner == OWNER_RX);
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    last_owner  <= owner;
                    tx_active_q <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    msg_vld_q   <= 1'b0;
                    tx_active_q <= 1'b0;
                    cnt         <= '0;
                end
            endcase
        end
    end

    assign sb_if.o_encoded_SB_msg    = msg_q;
    assign sb_if.o_msg_valid         = msg_vld_q;
    assign sb_if.o_done_tx           = done_tx_q;
    assign sb_if.o_done_rx           = done_rx_q;
    assign sb_if.o_tx_active         = tx_active_q;
    assign sb_if.o_falling_edge_busy = busy_fall;
    assign sb_if.o_timeout           = timeout_hit;

endmodule

// File: tb/tb_ltsm_sb_msg_arbiter.sv
// Directed bench for the sideband message arbiter, with a short timeout.
// Latency: each vector is one clock. Outputs are sampled 2 time units after the rising edge.
// Backpressure: i_SB_Busy is driven by the vectors to play the encoder.
module tb_ltsm_sb_msg_arbiter;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 i_clk = ~i_clk;

    ltsm_sb_msg_arbiter_if #(.SB_MSG_WIDTH(4)) bus ();

    ltsm_sb_msg_arbiter #(
        .SB_MSG_WIDTH   (4),
        .TIMEOUT_CYCLES (8),
        .CNT_WIDTH      (4)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .sb_if (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check that cycle's outputs, then advance to the next cycle.
    task automatic cyc(input string tag, input bit rst, input bit tx, input bit rx, input bit bsy,
                       input bit e_vld, input logic [3:0] e_msg, input bit e_dtx, input bit e_drx,
                       input bit e_act, input bit e_fe, input bit e_to);
        i_rst          = rst;
        bus.i_valid_tx = tx;
        bus.i_valid_rx = rx;
        bus.i_SB_Busy  = bsy;
        #1;
        chk({tag, ".vld"},  {31'd0, bus.o_msg_valid},         {31'd0, e_vld});
        chk({tag, ".msg"},  {28'd0, bus.o_encoded_SB_msg},    {28'd0, e_msg});
        chk({tag, ".dtx"},  {31'd0, bus.o_done_tx},           {31'd0, e_dtx});
        chk({tag, ".drx"},  {31'd0, bus.o_done_rx},           {31'd0, e_drx});
        chk({tag, ".act"},  {31'd0, bus.o_tx_active},         {31'd0, e_act});
        chk({tag, ".fe"},   {31'd0, bus.o_falling_edge_busy}, {31'd0, e_fe});
        chk({tag, ".to"},   {31'd0, bus.o_timeout},           {31'd0, e_to});
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst          = 1'b1;
        bus.i_valid_tx = 1'b0;
        bus.i_valid_rx = 1'b0;
        bus.i_SB_Busy  = 1'b0;
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_encoded_SB_msg_tx = 4'h0;
        bus.i_encoded_SB_msg_rx = 4'h0;
        do_reset();

        // The first vector is taken with reset still high, so it checks the reset state.
        cyc("rst",    1, 0, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0);

        // TX only. Busy is high in cycles 3-7 and falls in cycle 8.
        bus.i_encoded_SB_msg_tx = 4'h1;
        cyc("tx.c0",  0, 1, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0);
        cyc("tx.c1",  0, 1, 0, 0,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tx.c2",  0, 1, 0, 0,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tx.c3",  0, 1, 0, 1,  1, 4'h1, 0, 0, 1, 0, 0);
        for (int c = 4; c <= 7; c++)
            cyc($sformatf("tx.c%0d", c), 0, 1, 0, 1,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tx.c8",  0, 1, 0, 0,  1, 4'h1, 0, 0, 1, 1, 0);
        cyc("tx.c9",  0, 0, 0, 0,  0, 4'h1, 1, 0, 1, 0, 0);
        cyc("tx.c10", 0, 0, 0, 0,  0, 4'h1, 0, 0, 0, 0, 0);

        // Simultaneous requests straight out of reset: TX, then RX, then TX again.
        do_reset();
        bus.i_encoded_SB_msg_tx = 4'h1;
        bus.i_encoded_SB_msg_rx = 4'h2;
        cyc("tie.c0",  0, 1, 1, 0,  0, 4'h0, 0, 0, 0, 0, 0);
        cyc("tie.c1",  0, 1, 1, 0,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tie.c2",  0, 1, 1, 1,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tie.c3",  0, 1, 1, 1,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tie.c4",  0, 1, 1, 0,  1, 4'h1, 0, 0, 1, 1, 0);
        cyc("tie.c5",  0, 1, 1, 0,  0, 4'h1, 1, 0, 1, 0, 0);
        cyc("tie.c6",  0, 1, 1, 0,  0, 4'h1, 0, 0, 0, 0, 0);
        cyc("tie.c7",  0, 1, 1, 0,  1, 4'h2, 0, 0, 0, 0, 0);
        cyc("tie.c8",  0, 1, 1, 1,  1, 4'h2, 0, 0, 0, 0, 0);
        cyc("tie.c9",  0, 1, 1, 1,  1, 4'h2, 0, 0, 0, 0, 0);
        cyc("tie.c10", 0, 1, 1, 0,  1, 4'h2, 0, 0, 0, 1, 0);
        cyc("tie.c11", 0, 1, 1, 0,  0, 4'h2, 0, 1, 0, 0, 0);
        cyc("tie.c12", 0, 1, 1, 0,  0, 4'h2, 0, 0, 0, 0, 0);
        cyc("tie.c13", 0, 0, 0, 0,  1, 4'h1, 0, 0, 1, 0, 0);
        cyc("tie.c14", 0, 0, 0, 0,  0, 4'h1, 0, 0, 0, 0, 0);

        // RX withdraws in ISSUE (dropped quietly).
        // Then RX withdraws in the same cycle busy rises (busy wins), and drops again during BUSY.
        bus.i_encoded_SB_msg_tx = 4'h4;
        bus.i_encoded_SB_msg_rx = 4'h3;
        cyc("wd.c0",  0, 0, 1, 0,  0, 4'h1, 0, 0, 0, 0, 0);
        cyc("wd.c1",  0, 0, 1, 0,  1, 4'h3, 0, 0, 0, 0, 0);
        cyc("wd.c2",  0, 0, 0, 0,  1, 4'h3, 0, 0, 0, 0, 0);
        cyc("wd.c3",  0, 0, 0, 0,  0, 4'h3, 0, 0, 0, 0, 0);
        bus.i_encoded_SB_msg_rx = 4'h5;
        cyc("wd.c4",  0, 0, 1, 0,  0, 4'h3, 0, 0, 0, 0, 0);
        cyc("wd.c5",  0, 0, 0, 1,  1, 4'h5, 0, 0, 0, 0, 0);
        cyc("wd.c6",  0, 0, 0, 1,  1, 4'h5, 0, 0, 0, 0, 0);
        cyc("wd.c7",  0, 0, 0, 0,  1, 4'h5, 0, 0, 0, 1, 0);
        cyc("wd.c8",  0, 0, 0, 0,  0, 4'h5, 0, 1, 0, 0, 0);
        cyc("wd.c9",  0, 0, 0, 0,  0, 4'h5, 0, 0, 0, 0, 0);

        // Timeout: TX wins the tie (RX was last), busy never rises, RX is then granted.
        bus.i_encoded_SB_msg_tx = 4'h6;
        bus.i_encoded_SB_msg_rx = 4'h7;
        cyc("to.c0",  0, 1, 1, 0,  0, 4'h5, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 7; c++)
            cyc($sformatf("to.c%0d", c), 0, 1, 1, 0,  1, 4'h6, 0, 0, 1, 0, 0);
        cyc("to.c8",  0, 1, 1, 0,  1, 4'h6, 0, 0, 1, 0, 1);
        cyc("to.c9",  0, 1, 1, 0,  0, 4'h6, 0, 0, 0, 0, 0);
        cyc("to.c10", 0, 0, 1, 1,  1, 4'h7, 0, 0, 0, 0, 0);
        cyc("to.c11", 0, 0, 1, 0,  1, 4'h7, 0, 0, 0, 1, 0);
        cyc("to.c12", 0, 0, 0, 0,  0, 4'h7, 0, 1, 0, 0, 0);
        cyc("to.c13", 0, 0, 0, 0,  0, 4'h7, 0, 0, 0, 0, 0);

        // Reset during BUSY: everything clears, no done, and the held TX request is granted again.
        bus.i_encoded_SB_msg_tx = 4'h8;
        cyc("rb.c0",  0, 1, 0, 0,  0, 4'h7, 0, 0, 0, 0, 0);
        cyc("rb.c1",  0, 1, 0, 1,  1, 4'h8, 0, 0, 1, 0, 0);
        cyc("rb.c2",  0, 1, 0, 1,  1, 4'h8, 0, 0, 1, 0, 0);
        cyc("rb.c3",  1, 1, 0, 1,  1, 4'h8, 0, 0, 1, 0, 0);
        cyc("rb.c4",  0, 1, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0);
        cyc("rb.c5",  0, 0, 0, 0,  1, 4'h8, 0, 0, 1, 0, 0);
        cyc("rb.c6",  0, 0, 0, 0,  0, 4'h8, 0, 0, 0, 0, 0);

        // Busy falls while IDLE: the edge is flagged, but there is no done and no grant.
        cyc("fe.c0",  0, 0, 0, 1,  0, 4'h8, 0, 0, 0, 0, 0);
        cyc("fe.c1",  0, 0, 0, 0,  0, 4'h8, 0, 0, 0, 1, 0);
        cyc("fe.c2",  0, 0, 0, 0,  0, 4'h8, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
